uart_tx_buf: RTL and testbench
==============================

Name: uart_tx_buf

Overview:
Buffered UART transmitter, the transmit-direction counterpart of the buffered receive path. Bytes are pushed with a single-cycle `put` strobe into a ring FIFO. An internal 8N1 serializer drains the FIFO onto TX back-to-back. Sits between the application logic and the FPGA TX pin, e.g. to echo bytes popped from the receive buffer.

Parameters:
clk_freq, 12000000, system clock frequency in Hz
baud, 115200, line rate in bit/s; bit period DIV = clk_freq/baud clocks (integer division), DIV >= 2 required
tbuf_size, 16, FIFO depth in bytes; power of two, >= 2

Ports:
clk  input  1  system clock, all logic on rising edge
resetn  input  1  asynchronous active-low reset
put  input  1  push strobe; one byte written per cycle when high and not full
data  input  8  byte to push, sampled on the clk edge with put
full  output  1  FIFO holds tbuf_size bytes
empty  output  1  FIFO holds 0 bytes (serializer may still be shifting)
idle  output  1  FIFO empty AND serializer in IDLE (line quiescent)
overflow  output  1  sticky; set when put is asserted while full; cleared only by reset
TX  output  1  serial line, idle high

Behaviour:
- Reset (resetn low, asynchronous): FIFO pointers = 0, serializer in IDLE, TX = 1, full = 0, empty = 1, idle = 1, overflow = 0. Reset mid-frame aborts the frame immediately: TX goes high, no partial byte is resumed, and FIFO contents are discarded.
- FIFO: read and write pointers are log2(tbuf_size)+1 bits wide, with an extra wrap bit. empty = (rd == wr). full = (addresses equal AND wrap bits differ). Both flags are combinational from the registered pointers. Pointers wrap naturally modulo 2*tbuf_size.
- Push: on the clk edge with put=1 and full=0, mem[wr] <= data and wr <= wr+1. With put=1 and full=1 the byte is dropped, wr is unchanged and overflow <= 1. full is evaluated before any same-cycle pop, so a simultaneous pop does not make room.
- Pop: the serializer pops (rd <= rd+1) on the edge where it leaves IDLE or STOP to start a new frame. Push and pop in the same cycle are both honoured when not full/not empty.
- Serializer FSM, with a bit-period counter cnt counting 0..DIV-1 and a bit index 0..7:
  - IDLE: TX=1. If !empty: latch mem[rd] into the shift register, pop, cnt<=0, go to START.
  - START: TX=0 for DIV clocks, then go to DATA with bit index 0.
  - DATA: TX = shift[0], LSB first. Each bit lasts DIV clocks, then shift right. After bit 7 go to STOP.
  - STOP: TX=1 for DIV clocks. At the end, if !empty, pop and go directly to START (no idle gap); else go to IDLE.
- TX is a registered output, glitch-free.
- Latency: for a put accepted at edge N into an empty, idle block, empty drops after N. The FSM loads at edge N+1 and TX falls low at edge N+1, i.e. 1 clock after the accept edge. A full frame is 10*DIV clocks.
- Back-to-back frames: the stop bit is exactly DIV clocks, immediately followed by the next start bit.
- idle deasserts at the same edge that empty deasserts. It reasserts at the end of the last stop bit when the FIFO is empty.
- No parity, a single stop bit, and no flow control.

Decomposition:
- Shared package/header: frame constants (DATA_BITS=8, STOP_BITS=1), FSM state encodings (IDLE, START, DATA, STOP), and the log2 helper function used for the pointer width.
- One sub-module, uart_tx: the serializer FSM with a load/ready handshake (inputs tx_start, tx_data; output tx_busy). uart_tx_buf owns the FIFO and instantiates uart_tx, popping on tx_start.

Test Plan:
- Reset/idle (clk_freq=16, baud=1, DIV=16): hold resetn low, then release -> TX=1, empty=1, idle=1, full=0, overflow=0 for 100 clocks.
- Single byte: put 0xA5 -> TX low 1 clock after the accept edge. Line then shows 0,1,0,1,0,0,1,0,1,1, each bit 16 clocks. idle=1 exactly 160 clocks after TX fell.
- Back-to-back: put 0x55 then 0x0F on consecutive cycles -> two frames with no gap. The stop bit of frame 1 is exactly 16 clocks, and a receiver model decodes 0x55 then 0x0F.
- Full/overflow (tbuf_size=4): push 0x01..0x06 in consecutive cycles. The serializer pops 0x01 at the edge after its accept, so 0x02..0x05 are buffered and full=1 on the cycle 0x06 is presented. 0x06 is dropped and overflow=1. The line emits 0x01..0x05 only. After drain: empty=1, overflow still 1.
- Wrap-around (tbuf_size=4): stream 20 bytes 0x00..0x13, pushing whenever !full -> all 20 received in order, overflow=0.
- Reset mid-frame: assert resetn low during bit 3 of 0xFF -> TX=1 immediately (asynchronously). After release, empty=1 and no further frame is emitted.

Source files
------------

// File: rtl/uart_tx_buf_pkg.sv
// Shared definitions for the buffered UART transmitter: frame shape, serializer
// state encodings and the width helper used to size pointers and counters.
// Latency: n/a (declarations only).  Backpressure: n/a.
package uart_tx_buf_pkg;

   // 8N1 framing: one start bit, eight data bits, one stop bit.
   localparam int DATA_BITS = 8;
   localparam int STOP_BITS = 1;

   typedef logic [DATA_BITS-1:0] byte_t;

   // Serializer states, kept as plain constants so the encoding is fixed.
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_START = 2'd1;
   localparam logic [1:0] ST_DATA  = 2'd2;
   localparam logic [1:0] ST_STOP  = 2'd3;

   // Ceiling log2: number of bits needed to hold the values 0..n-1.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) begin
            r = i + 1;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/uart_tx_buf_if.sv
// Application-side push interface of the buffered UART transmitter.
// Latency: n/a (wires only).  Backpressure: full is advisory; a put while full
// is dropped and flagged on the sticky overflow bit.
// Ports: put/data (push strobe and byte), full/empty/idle/overflow (status).
interface uart_tx_buf_if;

   logic                   put;
   uart_tx_buf_pkg::byte_t data;
   logic                   full;
   logic                   empty;
   logic                   idle;
   logic                   overflow;

   // Application side: pushes bytes and watches the status flags.
   modport master (
      output put,
      output data,
      input  full,
      input  empty,
      input  idle,
      input  overflow
   );

   // Transmitter side: accepts bytes and reports its state.
   modport slave (
      input  put,
      input  data,
      output full,
      output empty,
      output idle,
      output overflow
   );

endinterface

// File: rtl/uart_tx_buf_tx.sv
// 8N1 serializer: shifts one byte LSB first, framed by a start and stop bit.
// Latency: tx goes low on the edge that accepts tx_start; a frame is 10*DIV clocks.
// Backpressure: tx_rdy high only in IDLE or on the last stop-bit clock; loads elsewhere are ignored.
// Ports: clk, resetn, tx_start/tx_data (load), tx_rdy, tx_busy, tx (registered line).
module uart_tx
   import uart_tx_buf_pkg::*;
#(
   parameter int DIV = 104
) (
   input  logic  clk,
   input  logic  resetn,
   input  logic  tx_start,
   input  byte_t tx_data,
   output logic  tx_rdy,
   output logic  tx_busy,
   output logic  tx
);

   localparam int CNT_W = (clog2(DIV) < 1) ? 1 : clog2(DIV);
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIV - 1);
   localparam logic [2:0]       DATA_LAST = 3'(DATA_BITS - 1);
   localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);

   logic [1:0]       state;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       bit_idx;
   byte_t            shift;
   logic             bit_end;
   logic             load;

   assign bit_end = (cnt == CNT_LAST);

   // Ready on the final clock of the last stop bit as well as in IDLE, so a
   // queued byte starts its start bit with no gap after the stop bit.
   assign tx_rdy  = (state == ST_IDLE) ||
                    ((state == ST_STOP) && bit_end && (bit_idx == STOP_LAST));
   assign tx_busy = (state != ST_IDLE);
   assign load    = tx_start && tx_rdy;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         bit_idx <= '0;
         shift   <= '0;
         tx      <= 1'b1;
      end else if (load) begin
         // The start bit is driven from this edge, one clock after the byte
         // became visible at the FIFO head.
         shift   <= tx_data;
         cnt     <= '0;
         bit_idx <= '0;
         state   <= ST_START;
         tx      <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               cnt <= '0;
               tx  <= 1'b1;
            end
            ST_START: begin
               if (bit_end) begin
                  cnt     <= '0;
                  bit_idx <= '0;
                  state   <= ST_DATA;
                  tx      <= shift[0];
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            ST_DATA: begin
               if (bit_end) begin
                  cnt <= '0;
                  if (bit_idx == DATA_LAST) begin
                     bit_idx <= '0;
                     state   <= ST_STOP;
                     tx      <= 1'b1;
                  end else begin
                     // Present the next bit now; shift[1] becomes shift[0].
                     bit_idx <= bit_idx + 3'd1;
                     shift   <= shift >> 1;
                     tx      <= shift[1];
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            ST_STOP: begin
               if (bit_end) begin
                  cnt <= '0;
                  if (bit_idx == STOP_LAST) begin
                     state <= ST_IDLE;
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
               tx <= 1'b1;
            end
            default: begin
               state <= ST_IDLE;
               tx    <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: rtl/uart_tx_buf.sv
// Buffered UART transmitter: ring FIFO of tbuf_size bytes drained by an 8N1 serializer.
// Latency: a byte pushed into an empty, idle block starts its start bit 1 clock after acceptance.
// Backpressure: none toward the pusher; puts while full are dropped and set sticky overflow.
// Ports: clk, resetn, bus (put/data in; full/empty/idle/overflow out), TX (serial line, idle high).
module uart_tx_buf
   import uart_tx_buf_pkg::*;
#(
   parameter int clk_freq  = 12000000,
   parameter int baud      = 115200,
   parameter int tbuf_size = 16
) (
   input  logic         clk,
   input  logic         resetn,
   uart_tx_buf_if.slave bus,
   output logic         TX
);

   localparam int DIV    = clk_freq / baud;
   localparam int ADDR_W = clog2(tbuf_size);
   localparam int PTR_W  = ADDR_W + 1;

   byte_t            mem [tbuf_size];
   logic [PTR_W-1:0] wr;
   logic [PTR_W-1:0] rd;
   logic             full;
   logic             empty;
   logic             push;
   logic             pop;
   logic             tx_rdy;
   logic             tx_busy;
   logic             overflow;
   byte_t            head;

   // The extra pointer bit separates "same slot, nothing stored" from
   // "same slot, one lap ahead".
   assign empty = (rd == wr);
   assign full  = (rd[ADDR_W-1:0] == wr[ADDR_W-1:0]) && (rd[ADDR_W] != wr[ADDR_W]);

   // full is taken from the registered pointers, so a pop on the same edge
   // never makes room for a push.
   assign push = bus.put && !full;
   assign pop  = tx_rdy && !empty;
   assign head = mem[rd[ADDR_W-1:0]];

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr       <= '0;
         rd       <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) begin
            wr <= wr + PTR_W'(1);
         end
         if (pop) begin
            rd <= rd + PTR_W'(1);
         end
         if (bus.put && full) begin
            overflow <= 1'b1;
         end
      end
   end

   // Storage needs no reset: clearing the pointers discards the contents.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr[ADDR_W-1:0]] <= bus.data;
      end
   end

   uart_tx #(
      .DIV (DIV)
   ) u_tx (
      .clk      (clk),
      .resetn   (resetn),
      .tx_start (pop),
      .tx_data  (head),
      .tx_rdy   (tx_rdy),
      .tx_busy  (tx_busy),
      .tx       (TX)
   );

   assign bus.full     = full;
   assign bus.empty    = empty;
   assign bus.idle     = empty && !tx_busy;
   assign bus.overflow = overflow;

endmodule

// File: tb/tb_uart_tx_buf.sv
// Bench for uart_tx_buf: cycle-level line/flag model plus a frame decoder
// that checks each received byte against a scoreboard queue.
module tb_uart_tx_buf;

   localparam int DIV   = 16;
   localparam int DEPTH = 4;
   localparam int FRAME = 10 * DIV;

   logic clk    = 1'b0;
   logic resetn = 1'b1;
   logic TX;

   uart_tx_buf_if bus ();

   uart_tx_buf #(
      .clk_freq  (16),
      .baud      (1),
      .tbuf_size (DEPTH)
   ) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus),
      .TX     (TX)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: bytes waiting in the buffer, the frame currently on the
   // line (10 bits, start first) and the edge on which it began.
   logic [7:0] m_fifo [$];
   logic [7:0] sb_q [$];
   int         cyc      = 0;
   bit         m_active = 1'b0;
   int         m_start  = 0;
   logic [9:0] m_frame  = 10'h3FF;
   bit         m_ovf    = 1'b0;
   bit         m_was_full;
   bit         chk_en   = 1'b0;

   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         m_fifo.delete();
         sb_q.delete();
         m_active = 1'b0;
         m_ovf    = 1'b0;
      end else begin
         m_was_full = (m_fifo.size() == DEPTH);
         cyc++;
         if (m_active && (cyc >= m_start + FRAME)) begin
            m_active = 1'b0;
         end
         if (!m_active && (m_fifo.size() != 0)) begin
            m_frame  = {1'b1, m_fifo.pop_front(), 1'b0};
            m_start  = cyc;
            m_active = 1'b1;
         end
         if (bus.put) begin
            if (m_was_full) begin
               m_ovf = 1'b1;
            end else begin
               m_fifo.push_back(bus.data);
               sb_q.push_back(bus.data);
            end
         end
      end
   end

   // Per-cycle comparison of line and flags against the model.
   logic exp_tx;
   always @(negedge clk) begin
      if (chk_en) begin
         exp_tx = m_active ? m_frame[(cyc - m_start) / DIV] : 1'b1;
         check("tx_line",  TX,           exp_tx);
         check("full",     bus.full,     m_fifo.size() == DEPTH);
         check("empty",    bus.empty,    m_fifo.size() == 0);
         check("idle",     bus.idle,     (m_fifo.size() == 0) && !m_active);
         check("overflow", bus.overflow, m_ovf);
      end
   end

   // Receiver: finds a start bit, samples mid-bit, pops the scoreboard.
   logic [7:0] rx_byte;
   logic       rx_stop;
   bit         rx_abort;
   initial begin
      forever begin
         @(negedge clk);
         if (chk_en && resetn && (TX == 1'b0)) begin
            rx_abort = 1'b0;
            repeat (DIV / 2) begin
               @(negedge clk);
               if (!resetn) rx_abort = 1'b1;
            end
            if (TX != 1'b0) rx_abort = 1'b1;
            for (int b = 0; b < 8; b++) begin
               repeat (DIV) begin
                  @(negedge clk);
                  if (!resetn) rx_abort = 1'b1;
               end
               rx_byte[b] = TX;
            end
            repeat (DIV) begin
               @(negedge clk);
               if (!resetn) rx_abort = 1'b1;
            end
            rx_stop = TX;
            if (!rx_abort) begin
               check("rx_stop_bit", rx_stop, 1);
               if (sb_q.size() == 0) begin
                  check("rx_unexpected_frame", rx_byte, -1);
               end else begin
                  check("rx_byte", rx_byte, sb_q.pop_front());
               end
            end
         end
      end
   end

   task automatic put_byte(input logic [7:0] b);
      bus.put  = 1'b1;
      bus.data = b;
      @(negedge clk);
      bus.put  = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      while (!bus.idle && n < budget) begin
         @(negedge clk);
         n++;
      end
      repeat (2) @(negedge clk);
      check("idle_reached", bus.idle, 1);
   endtask

   // Asserts reset between edges and checks the line is released at once.
   task automatic pulse_reset();
      @(negedge clk);
      #2 resetn = 1'b0;
      #1 check("reset_tx_async", TX, 1);
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
   endtask

   int sent;
   int guard;

   initial begin
      bus.put  = 1'b0;
      bus.data = '0;
      #1 resetn = 1'b0;
      chk_en = 1'b1;
      repeat (3) @(negedge clk);
      resetn = 1'b1;
      repeat (100) @(negedge clk);
      check("reset_overflow", bus.overflow, 0);
      check("reset_idle", bus.idle, 1);

      // Single byte.
      put_byte(8'hA5);
      wait_idle(3 * FRAME);

      // Two bytes on consecutive cycles: frames must abut.
      put_byte(8'h55);
      put_byte(8'h0F);
      wait_idle(4 * FRAME);

      // Overfill a 4-deep buffer: 0x06 is dropped.
      for (int i = 1; i <= 6; i++) put_byte(8'(i));
      check("overflow_set", bus.overflow, 1);
      wait_idle(8 * FRAME);
      check("overflow_sticky", bus.overflow, 1);
      check("empty_after_drain", bus.empty, 1);

      // Pointer wrap: 20 bytes, pushing only when there will be room.
      pulse_reset();
      sent  = 0;
      guard = 0;
      while (sent < 20 && guard < 30 * FRAME) begin
         if (m_fifo.size() < DEPTH) begin
            bus.put  = 1'b1;
            bus.data = 8'(sent);
            sent++;
         end else begin
            bus.put = 1'b0;
         end
         @(negedge clk);
         guard++;
      end
      bus.put = 1'b0;
      check("wrap_all_sent", sent, 20);
      wait_idle(6 * FRAME);
      check("wrap_no_overflow", bus.overflow, 0);
      check("wrap_all_received", sb_q.size(), 0);

      // Random bytes with random gaps, some arriving while full.
      for (int i = 0; i < 14; i++) begin
         put_byte(8'($urandom_range(0, 255)));
         repeat ($urandom_range(0, 200)) @(negedge clk);
      end
      wait_idle(8 * FRAME);
      check("random_all_received", sb_q.size(), 0);

      // Reset during data bit 3 of 0xFF.
      pulse_reset();
      put_byte(8'hFF);
      repeat (70) @(negedge clk);
      check("midframe_busy", bus.idle, 0);
      pulse_reset();
      repeat (2 * FRAME) @(negedge clk);
      check("midframe_empty", bus.empty, 1);
      check("midframe_line_high", TX, 1);

      check("scoreboard_drained", sb_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
